gradient_div_sequencer: RTL and testbench
=========================================

GRADIENT_DIV_SEQUENCER -- requirements
Module: gradient_div_sequencer

Interface
REQ-001 The module SHALL have one clock and one reset: reset is synchronous and active-low; ports are named clock and i_nrst.
REQ-002 Parameter N_OPS, default 7, SHALL be the number of divisions per job, all sharing one denominator.
REQ-003 Parameter OUTSIZE, default 20, SHALL be the width of each stored quotient.
REQ-004 Parameter DIV_LATENCY, default 6, SHALL be the cycles from an operand pair presented on div_* to its quotient appearing on div_quotient.
REQ-005 Port clock, input, 1 bit, SHALL be the rising-edge clock.
REQ-006 Port i_nrst, input, 1 bit, SHALL be the synchronous active-low reset.
REQ-007 Port i_start, input, 1 bit, SHALL request a job; it is accepted only when o_busy=0.
REQ-008 Port i_numerators, input, 32*N_OPS bits, SHALL carry the signed numerators; op k is in bits [32k+31:32k].
REQ-009 Port i_denominator, input, 22 bits, SHALL carry the signed shared denominator (triangle determinant).
REQ-010 Port o_busy, output, 1 bit, SHALL be high while a job is in flight.
REQ-011 Port o_done, output, 1 bit, SHALL be a single-cycle pulse marking that o_quotients holds a job's results.
REQ-012 Port o_quotients, output, OUTSIZE*N_OPS bits, SHALL carry the signed results; op k is in bits [OUTSIZE*k+OUTSIZE-1:OUTSIZE*k].
REQ-013 Port div_numerator, output, 32 bits, SHALL drive the external pipelined divider numerator.
REQ-014 Port div_denominator, output, 22 bits, SHALL drive the external pipelined divider denominator.
REQ-015 Port div_quotient, input, OUTSIZE bits, SHALL receive the external divider quotient.

Function
REQ-016 State machine states SHALL be IDLE, ISSUE, DRAIN, ZERO and DONE.
REQ-017 IDLE SHALL latch i_numerators and i_denominator into internal registers at the edge on which i_start=1 (call that cycle 0), regardless of input changes afterwards.
REQ-018 From IDLE, the next state SHALL be ISSUE when the latched denominator is non-zero, or ZERO when it is zero.
REQ-019 ISSUE SHALL last exactly N_OPS cycles (cycles 1..N_OPS); in cycle 1+k it SHALL drive div_numerator = latched op k and div_denominator = latched denominator, one op per cycle with no bubbles.
REQ-020 Outside ISSUE, div_numerator SHALL be 0; div_denominator SHALL hold the last latched value.
REQ-021 A DIV_LATENCY-deep valid/index shift register SHALL track issued ops; the quotient for op k SHALL be captured from div_quotient at the end of cycle 1+k+DIV_LATENCY into slot k.
REQ-022 DRAIN SHALL follow ISSUE and last until the last op is captured (end of cycle N_OPS+DIV_LATENCY).
REQ-023 DONE SHALL be occupied for one cycle (cycle N_OPS+DIV_LATENCY+1, cycle 14 for the defaults), asserting o_done=1 and o_busy=0, then return to IDLE.
REQ-024 A new i_start SHALL be accepted in the DONE cycle; the sequencer then goes directly to ISSUE or ZERO.
REQ-025 ZERO, taken on a zero denominator, SHALL last one cycle (cycle 1): it clears all quotient slots to 0 and issues nothing to the divider; DONE follows in cycle 2.
REQ-026 o_busy SHALL be 1 in ISSUE, DRAIN and ZERO, and 0 in IDLE and DONE.
REQ-027 i_start asserted while o_busy=1 SHALL be ignored, with no queuing.
REQ-028 o_quotients SHALL hold its values from o_done until overwritten by captures of the next job; slots not yet captured keep their previous values.
REQ-029 Quotients SHALL be stored as the low OUTSIZE bits of div_quotient with no saturation, so results that overflow wrap modulo 2^OUTSIZE.

Reset
REQ-030 When i_nrst=0 at a clock edge, the state SHALL be IDLE, o_busy=0, o_done=0, o_quotients=0, div_numerator=0, div_denominator=0 and the valid pipe cleared.
REQ-031 A reset asserted mid-job SHALL abort the job, with no o_done and no later captures of in-flight quotients.
REQ-032 An i_start coincident with i_nrst=0 SHALL be ignored.

Verification
REQ-033 Defaults, denominator 4, numerators 0,4,8,...,24, divider model of latency 6: o_done SHALL pulse in cycle 14 only, with quotients 0..6.
REQ-034 Negative values, numerator -100 and denominator 7: the quotient SHALL be -14, truncated toward zero, sign-correct in OUTSIZE bits.
REQ-035 Zero denominator with non-zero numerators: o_done SHALL pulse in cycle 2, all quotients SHALL be 0, and div_numerator SHALL stay 0 throughout.
REQ-036 Back-to-back jobs with i_start held high: the second job's ISSUE SHALL begin the cycle after DONE, and o_done SHALL pulse at cycles 14 and 28.
REQ-037 i_start pulsed in cycle 5 of a job: it SHALL be ignored, with exactly one o_done and the results of the first job.
REQ-038 i_nrst pulled low in cycle 9: all outputs SHALL be 0 the next cycle, with no o_done; a fresh job afterwards SHALL complete correctly in 14 cycles.

Source files
------------

// File: rtl/gradient_div_sequencer.sv
// gradient_div_sequencer: runs N_OPS divisions that share one denominator through an external
// pipelined divider and collects the quotients into per-op slots.
module gradient_div_sequencer #(
    parameter int N_OPS       = 7,
    parameter int OUTSIZE     = 20,
    parameter int DIV_LATENCY = 6
) (
    input  logic                       clock,
    input  logic                       i_nrst,
    input  logic                       i_start,
    input  logic [32*N_OPS-1:0]        i_numerators,
    input  logic [21:0]                i_denominator,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [OUTSIZE*N_OPS-1:0]   o_quotients,
    output logic [31:0]                div_numerator,
    output logic [21:0]                div_denominator,
    input  logic [OUTSIZE-1:0]         div_quotient
);
    localparam int IW = N_OPS > 1 ? $clog2(N_OPS) : 1;
    localparam logic [IW-1:0] LAST = IW'(N_OPS - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, ZERO, DONE} state_t;

    state_t                     state_q, state_d;
    logic [32*N_OPS-1:0]        num_q, num_d;
    logic [21:0]                den_q, den_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [DIV_LATENCY-1:0]     vld_q, vld_d;
    logic [IW-1:0]              pidx_q [DIV_LATENCY];
    logic [IW-1:0]              pidx_d [DIV_LATENCY];
    logic [OUTSIZE*N_OPS-1:0]   quo_q, quo_d;
    logic                       accept;

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        den_d   = den_q;
        idx_d   = idx_q;
        quo_d   = quo_q;
        accept  = i_start && (state_q == IDLE || state_q == DONE);
        // Each issued op travels with its slot index until the divider returns its quotient.
        vld_d[0]  = state_q == ISSUE;
        pidx_d[0] = idx_q;
        for (int j = 1; j < DIV_LATENCY; j++) begin
            vld_d[j]  = vld_q[j-1];
            pidx_d[j] = pidx_q[j-1];
        end
        if (vld_q[DIV_LATENCY-1])
            quo_d[int'(pidx_q[DIV_LATENCY-1])*OUTSIZE +: OUTSIZE] = div_quotient;
        if (accept) begin
            num_d   = i_numerators;
            den_d   = i_denominator;
            idx_d   = '0;
            state_d = (i_denominator != '0) ? ISSUE : ZERO;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end else if (state_q == ZERO) begin
            quo_d   = '0;
            state_d = DONE;
        end else if (state_q == ISSUE) begin
            idx_d   = idx_q + 1'b1;
            state_d = (idx_q == LAST) ? DRAIN : ISSUE;
        end else if (state_q == DRAIN && vld_q[DIV_LATENCY-1] && pidx_q[DIV_LATENCY-1] == LAST) begin
            state_d = DONE;
        end
    end

    always_ff @(posedge clock) begin
        if (!i_nrst) begin
            state_q <= IDLE;
            num_q   <= '0;
            den_q   <= '0;
            idx_q   <= '0;
            vld_q   <= '0;
            quo_q   <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            den_q   <= den_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            quo_q   <= quo_d;
        end
    end

    // Slot indices are only consulted alongside their valid bit, so they need no reset.
    always_ff @(posedge clock) pidx_q <= pidx_d;

    assign div_numerator   = (state_q == ISSUE) ? num_q[int'(idx_q)*32 +: 32] : '0;
    assign div_denominator = den_q;
    assign o_quotients     = quo_q;
    assign o_busy          = state_q == ISSUE || state_q == DRAIN || state_q == ZERO;
    assign o_done          = state_q == DONE;
endmodule

// File: tb/tb_gradient_div_sequencer.sv
// tb_gradient_div_sequencer: table vectors, random jobs against an arithmetic model, and
// hand-written back-to-back, ignored-start and mid-job reset sequences.
module tb_gradient_div_sequencer;
    localparam int N  = 7;
    localparam int OS = 20;
    localparam int L  = 6;

    logic              clk = 1'b0;
    logic              i_nrst, i_start;
    logic [32*N-1:0]   i_numerators;
    logic [21:0]       i_denominator;
    logic              o_busy, o_done;
    logic [OS*N-1:0]   o_quotients;
    logic [31:0]       div_numerator;
    logic [21:0]       div_denominator;
    logic [OS-1:0]     div_quotient;

    int n_pass = 0;
    int n_tot  = 0;

    gradient_div_sequencer #(.N_OPS(N), .OUTSIZE(OS), .DIV_LATENCY(L)) dut (
        .clock(clk), .i_nrst(i_nrst), .i_start(i_start), .i_numerators(i_numerators),
        .i_denominator(i_denominator), .o_busy(o_busy), .o_done(o_done),
        .o_quotients(o_quotients), .div_numerator(div_numerator),
        .div_denominator(div_denominator), .div_quotient(div_quotient)
    );

    always #5 clk = ~clk;

    // External divider: truncating signed division, L cycles from operands to quotient.
    logic signed [31:0] pn [L];
    logic signed [21:0] pd [L];
    always @(posedge clk) begin
        pn[0] <= div_numerator;
        pd[0] <= div_denominator;
        for (int j = 1; j < L; j++) begin
            pn[j] <= pn[j-1];
            pd[j] <= pd[j-1];
        end
    end
    always_comb div_quotient = (pd[L-1] == 0) ? '0 : OS'(longint'(pn[L-1]) / longint'(pd[L-1]));

    function automatic logic [OS*N-1:0] model(input logic [32*N-1:0] nums, input logic [21:0] den);
        logic [OS*N-1:0] r;
        longint q;
        r = '0;
        for (int k = 0; k < N; k++) begin
            q = (den == 0) ? 0 : longint'($signed(nums[32*k +: 32])) / longint'($signed(den));
            r[OS*k +: OS] = q[OS-1:0];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic run_job(input string nm, input logic [32*N-1:0] nums, input logic [21:0] den,
                           input logic [OS*N-1:0] expq, input int expcyc);
        int  cyc;
        logic numz;
        @(negedge clk);
        i_numerators = nums; i_denominator = den; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_numerators = {N{$urandom}};
        i_denominator = 22'($urandom);
        chk({nm, " busy c1"}, o_busy, 1);
        cyc  = 1;
        numz = 1'b1;
        while (!o_done && cyc < 40) begin
            if (div_numerator != 0) numz = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk({nm, " done cycle"}, cyc, expcyc);
        chk({nm, " quotients"}, o_quotients, expq);
        chk({nm, " busy in done"}, o_busy, 0);
        if (den == 0) chk({nm, " div_num zero"}, numz, 1);
        @(negedge clk);
        chk({nm, " done one pulse"}, o_done, 0);
    endtask

    typedef struct {
        int n[N];
        int d;
        int q[N];
        int cyc;
    } vec_t;

    vec_t            tv[5];
    logic [32*N-1:0] nums, nums_b;
    logic [OS*N-1:0] expq, expq_b;
    logic [21:0]     den;
    int              dones, d1, d2;

    initial begin
        tv[0] = '{n:'{0, 4, 8, 12, 16, 20, 24}, d:4, q:'{0, 1, 2, 3, 4, 5, 6}, cyc:14};
        tv[1] = '{n:'{-100, 100, -7, 6, -6, 0, 14}, d:7, q:'{-14, 14, -1, 0, 0, 0, 2}, cyc:14};
        tv[2] = '{n:'{5, -9, 100, 1, 2, 3, 4}, d:0, q:'{0, 0, 0, 0, 0, 0, 0}, cyc:2};
        tv[3] = '{n:'{10, -10, 9, 1, -1, 3000000, 0}, d:-3, q:'{-3, 3, -3, 0, 0, 48576, 0}, cyc:14};
        tv[4] = '{n:'{524288, -524288, 1048577, 7, -7, 1, -1}, d:1, q:'{-524288, -524288, 1, 7, -7, 1, -1}, cyc:14};

        i_nrst = 1'b0; i_start = 1'b1; i_numerators = '1; i_denominator = 22'd5;
        repeat (3) @(negedge clk);
        chk("reset busy", o_busy, 0);
        chk("reset done", o_done, 0);
        chk("reset quotients", o_quotients, 0);
        chk("reset div_num", div_numerator, 0);
        chk("reset div_den", div_denominator, 0);
        i_start = 1'b0;
        i_nrst  = 1'b1;

        for (int t = 0; t < 5; t++) begin
            for (int k = 0; k < N; k++) begin
                nums[32*k +: 32] = 32'(tv[t].n[k]);
                expq[OS*k +: OS] = OS'(tv[t].q[k]);
            end
            run_job($sformatf("vec%0d", t), nums, 22'(tv[t].d), expq, tv[t].cyc);
        end

        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < N; k++) nums[32*k +: 32] = $urandom;
            den = ($urandom_range(0, 4) == 0) ? 22'd0 :
                  ($urandom_range(0, 1) == 0) ? 22'($urandom_range(1, 50)) : 22'($urandom);
            run_job($sformatf("rnd%0d", r), nums, den, model(nums, den), den == 0 ? 2 : 14);
        end

        // Back-to-back jobs with i_start held high.
        for (int k = 0; k < N; k++) begin
            nums[32*k +: 32]   = 32'(4 * k);
            nums_b[32*k +: 32] = 32'(-7 * k - 3);
        end
        expq   = model(nums, 22'd4);
        expq_b = model(nums_b, 22'd7);
        dones = 0; d1 = 0; d2 = 0;
        @(negedge clk);
        i_numerators = nums; i_denominator = 22'd4; i_start = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc <= 35; cyc++) begin
            if (o_done) begin
                dones++;
                if (dones == 1) begin
                    d1 = cyc;
                    chk("b2b first quotients", o_quotients, expq);
                    i_numerators = nums_b; i_denominator = 22'd7;
                end else begin
                    d2 = cyc;
                    chk("b2b second quotients", o_quotients, expq_b);
                    i_start = 1'b0;
                end
            end
            if (cyc == 15) chk("b2b issue after done", div_numerator, nums_b[31:0]);
            @(negedge clk);
        end
        i_start = 1'b0;
        chk("b2b first done", d1, 14);
        chk("b2b second done", d2, 28);
        chk("b2b done count", dones, 2);

        // Start request while busy is dropped.
        dones = 0; d1 = 0;
        i_numerators = nums_b; i_denominator = 22'd7; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int cyc = 1; cyc <= 35; cyc++) begin
            if (cyc == 5) begin
                i_start = 1'b1; i_numerators = nums; i_denominator = 22'd0;
            end else i_start = 1'b0;
            if (o_done) begin
                dones++;
                d1 = cyc;
                chk("ignored start quotients", o_quotients, expq_b);
            end
            @(negedge clk);
        end
        i_start = 1'b0;
        chk("ignored start done count", dones, 1);
        chk("ignored start done cycle", d1, 14);

        // Reset in cycle 9, with a coincident start request.
        i_numerators = nums; i_denominator = 22'd4; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (8) @(negedge clk);
        i_nrst = 1'b0; i_start = 1'b1;
        @(negedge clk);
        chk("midreset busy", o_busy, 0);
        chk("midreset done", o_done, 0);
        chk("midreset quotients", o_quotients, 0);
        chk("midreset div_num", div_numerator, 0);
        chk("midreset div_den", div_denominator, 0);
        i_nrst = 1'b1; i_start = 1'b0;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            if (o_done || o_busy) dones++;
            @(negedge clk);
        end
        chk("midreset no activity", dones, 0);
        chk("midreset quotients kept 0", o_quotients, 0);
        run_job("after reset", nums, 22'd4, expq, 14);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
